// File: rtl/trig_chain_loader_pkg.sv
// Shared definitions for the D_Trig chain load controller: FSM encoding
// and the legal range of the chain length.
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LATCH = 2'b10,
        ST_RSVD  = 2'b11
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic logic width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/trig_chain_loader_shift_bit_cnt.sv
// Bit counter for the serial shift phase; flags the final bit of a word.
module shift_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign last = (count_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/trig_chain_loader.sv
// Accepts a parallel word, shifts it serially into a D_Trig chain, then
// pulses the latch enable and reports completion.
module trig_chain_loader
    import trig_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    input  logic             abort,
    output logic             SD,
    output logic             SE,
    output logic             LE,
    output logic             busy,
    output logic             done
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("trig_chain_loader: WIDTH out of range");
    end

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic [WIDTH-1:0] shift_msb, shift_lsb;
    logic             order_reg, order_next;
    logic             done_reg, done_next;
    logic             cnt_clr, cnt_inc, cnt_last;

    // Shifted copies of the shadow: each moves bits toward the emitting end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_msb_fill
                assign shift_msb[gi] = 1'b0;
            end else begin : g_msb_move
                assign shift_msb[gi] = shadow_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_lsb_fill
                assign shift_lsb[gi] = 1'b0;
            end else begin : g_lsb_move
                assign shift_lsb[gi] = shadow_reg[gi+1];
            end
        end
    endgenerate

    shift_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (C),
        .srst (R),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    always_ff @(posedge C) begin
        if (R) begin
            state_reg  <= ST_IDLE;
            shadow_reg <= '0;
            order_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shadow_reg <= shadow_next;
            order_reg  <= order_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shadow_next = shadow_reg;
        order_next  = order_reg;
        done_next   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    shadow_next = in_data;
                    order_next  = msb_first;
                    cnt_clr     = 1'b1;
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    shadow_next = '0;
                    cnt_clr     = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    shadow_next = order_reg ? shift_msb : shift_lsb;
                    cnt_inc     = 1'b1;
                    if (cnt_last) begin
                        state_next = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // in_ready is the only output that looks at R directly, so no word is
    // taken on the edge that is being reset.
    always_comb begin
        in_ready = (state_reg == ST_IDLE) && !R;
        SE       = (state_reg == ST_SHIFT);
        LE       = (state_reg == ST_LATCH);
        busy     = (state_reg == ST_SHIFT) || (state_reg == ST_LATCH);
        SD       = 1'b0;
        if (state_reg == ST_SHIFT) begin
            SD = order_reg ? shadow_reg[WIDTH-1] : shadow_reg[0];
        end
    end

    assign done = done_reg;

endmodule
